sram_req_ctrl: RTL and testbench
================================

# sram_req_ctrl

Initiator-side controller for the single-port synchronous SRAM macro: it drives CS/WE/A/BYTE/DI and captures DO one cycle later. After reset it zero-fills the whole array, then accepts valid/ready requests from a core or bus bridge. Read data is returned through a 2-entry response buffer, so `rsp_ready` back-pressure never loses SRAM output. It sits between the data/instruction bus fabric and each SRAM instance.

## Interface
- `AW`, 14, SRAM word-address width (depth 2^AW)
- `DW`, 32, data width; byte-enable width is DW/8
- `INIT_EN`, 1, 1 = zero-fill the array after reset; 0 = skip the fill
- `clk`  in  1  clock; all SRAM-side signals are sampled by the SRAM on the rising edge
- `rstn`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when high together with `req_valid`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  AW  word address
- `req_byte`  in  DW/8  byte-enables (writes only)
- `req_wdata`  in  DW  write data
- `rsp_valid`  out  1  read data available
- `rsp_ready`  in  1  consumer accepts read data
- `rsp_rdata`  out  DW  read data
- `init_done`  out  1  high once the controller is in RUN
- `sram_cs`, `sram_we`  out  1  SRAM chip-select and write-enable
- `sram_a`  out  AW  SRAM address
- `sram_byte`  out  DW/8  SRAM byte-enables
- `sram_di`  out  DW  SRAM write data
- `sram_do`  in  DW  SRAM registered read data, valid in the cycle after a CS=1, WE=0 access

## Operation
- FSM states and transitions:
  - Reset state is RST.
  - RST → INIT when `INIT_EN` = 1; RST → RUN when `INIT_EN` = 0. RST always lasts exactly one cycle.
  - INIT → RUN after the write to the last address, 2^AW−1.
- INIT:
  - Drives cs=1, we=1, byte=all-ones, di=0 every cycle.
  - `sram_a` is a counter running 0 → 2^AW−1, one word per cycle.
  - `req_ready` = 0 throughout.
- RUN:
  - `sram_cs` = `req_valid & req_ready`.
  - `sram_we` = `req_write`.
  - `sram_a`, `sram_byte`, `sram_di` pass through from the request combinationally.
  - The SRAM register provides the pipeline stage.
- Writes produce no response. Reads produce exactly one response each, in request order.
- Credit rule: `req_ready` = RUN & ((`count` + `inflight` − (`rsp_valid & rsp_ready`)) < 2).
  - `count` = entries held in the response FIFO.
  - `inflight` = 1 if a read was issued in the previous cycle.
  - The rule applies to reads and writes alike; `req_ready` does not depend on `req_write`.
- `inflight` data (`sram_do`) is pushed into the FIFO at the end of the cycle it is valid.
- FIFO push and pop in the same cycle are both allowed.
- While `rstn` is low, all outputs are 0. This holds during RST as well.
- In RUN with no accepted request, `sram_cs` = 0 and `sram_we` = `sram_a` = `sram_byte` = `sram_di` = 0.
- Reset mid-operation (including mid-INIT):
  - FIFO is emptied and `inflight` is cleared.
  - `init_done` drops and the FSM returns to RST; a fresh full fill follows when `INIT_EN` = 1.
  - Array contents are undefined until the fill completes.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `init_done` = 0, all `sram_*` = 0.
- Init duration: 1 cycle (RST) + 2^AW cycles (INIT). With `INIT_EN` = 0 the duration is 1 cycle. `init_done` rises in the first RUN cycle.
- Read latency: accepted in cycle N → `sram_do` valid in N+1 → `rsp_valid` in N+2 (with an empty FIFO).
- Throughput: one read per cycle sustained while `rsp_ready` = 1. Back-to-back writes are accepted one per cycle while credit remains.
- Back-pressure:
  - With `rsp_ready` = 0, at most 2 reads are accepted; `req_ready` stays 0 until a pop.
  - `rsp_rdata` and `rsp_valid` are held stable while `rsp_valid & !rsp_ready`.
- Write followed by a read of the same address in the next cycle returns the new data.
- Byte-enables apply only to written bytes; bytes with enable 0 keep their previous value.

## Structure
- Package `sram_ctrl_pkg`:
  - FSM state enum `{RST, INIT, RUN}`.
  - Default `AW`/`DW` constants.
- Sub-module `sram_rsp_fifo`: 2-entry DW-wide FIFO.
  - Ports: push, pop, full, empty, count.
  - Same-cycle push/pop supported when full (pop first).
- Top level holds the FSM, the init counter, the credit logic and the SRAM mux.

## Test plan
- Reset, `INIT_EN` = 1, `AW` = 4:
  - `init_done` rises exactly 17 cycles after `rstn` release.
  - Reading all 16 addresses returns 0.
- Write 0xDEADBEEF, byte=4'b1111 to addr 5; next cycle read addr 5 → `rsp_rdata` = 0xDEADBEEF two cycles after acceptance.
- Write 0x11223344 to addr 2, then byte=4'b0010 with data 0x0000AA00 → read returns 0x1122AA44.
- `rsp_ready` held 0, issue 4 reads of addrs 0–3:
  - Only 2 are accepted.
  - After raising `rsp_ready`, responses arrive in order with no loss.
  - One read per cycle at steady state.
- Assert `rstn` low in INIT when the counter = 7:
  - All outputs 0 while `rstn` is low.
  - After release, a full 17-cycle fill restarts from addr 0.
- `INIT_EN` = 0: `init_done` rises 1 cycle after release; the first request is accepted in that cycle.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the SRAM request controller.
package sram_ctrl_pkg;

    localparam int DEF_AW = 14;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        RST  = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Observation bundle for checkers: FSM state plus response-path occupancy.
    typedef struct packed {
        state_e     state;
        logic       inflight;
        logic       fifo_full;
        logic [1:0] fifo_count;
    } dbg_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry response buffer; head entry is presented combinationally.
module sram_rsp_fifo #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // A pop frees the head slot first, so a push into a full buffer is legal in that cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for a single-port synchronous SRAM: zero-fill after
// reset, then valid/ready requests with reads returned through a 2-entry buffer.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter bit INIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW/8-1:0] req_byte,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            init_done,
    output logic            sram_cs,
    output logic            sram_we,
    output logic [AW-1:0]   sram_a,
    output logic [DW/8-1:0] sram_byte,
    output logic [DW-1:0]   sram_di,
    input  logic [DW-1:0]   sram_do,
    output dbg_t            dbg
);

    // Handshakes: a transfer happens in every cycle where valid and ready are both
    // high at the rising edge; valid never waits on ready, and ready may depend on valid
    // only through the response pop (rsp_valid & rsp_ready), never on req_write.

    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_init_cnt;
    logic          r_inflight;
    logic          w_accept;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [1:0]    w_count;
    logic [2:0]    w_credit_used;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sram_cs     = 1'b0;
        sram_we     = 1'b0;
        sram_a      = '0;
        sram_byte   = '0;
        sram_di     = '0;
        case (r_state)
            RST: begin
                w_state_nxt = INIT_EN ? INIT : RUN;
            end
            INIT: begin
                sram_cs   = 1'b1;
                sram_we   = 1'b1;
                sram_byte = '1;
                sram_a    = r_init_cnt;
                if (r_init_cnt == '1) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_accept) begin
                    sram_cs   = 1'b1;
                    sram_we   = req_write;
                    sram_a    = req_addr;
                    sram_byte = req_byte;
                    sram_di   = req_wdata;
                end
            end
            default: begin
                w_state_nxt = RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end else begin
            r_init_cnt <= '0;
        end
    end

    // A read issued this cycle has its data on sram_do next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept && !req_write;
        end
    end

    // Buffer slots already spoken for after this cycle's pop; a new request needs one free.
    assign w_pop         = rsp_valid && rsp_ready;
    assign w_credit_used = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign req_ready     = (r_state == RUN) && (w_credit_used < 3'd2);
    assign w_accept      = req_valid && req_ready;

    sram_rsp_fifo #(
        .DW (DW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (r_inflight),
        .push_data (sram_do),
        .pop       (w_pop),
        .head_data (rsp_rdata),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign rsp_valid      = !w_empty;
    assign init_done      = (r_state == RUN);

    assign dbg.state      = r_state;
    assign dbg.inflight   = r_inflight;
    assign dbg.fifo_full  = w_full;
    assign dbg.fifo_count = w_count;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural SRAM and a read scoreboard.
`timescale 1ns/1ps
module tb_sram_req_ctrl;
    import sram_ctrl_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = DW/8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_byte;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done, sram_cs, sram_we;
    logic [AW-1:0] sram_a;
    logic [BW-1:0] sram_byte;
    logic [DW-1:0] sram_di, sram_do;
    dbg_t          dbg;

    logic          rstn0;
    logic          req_valid0, req_ready0, req_write0;
    logic [AW-1:0] req_addr0;
    logic [BW-1:0] req_byte0;
    logic [DW-1:0] req_wdata0;
    logic          rsp_valid0, rsp_ready0;
    logic [DW-1:0] rsp_rdata0;
    logic          init_done0, sram_cs0, sram_we0;
    logic [AW-1:0] sram_a0;
    logic [BW-1:0] sram_byte0;
    logic [DW-1:0] sram_di0, sram_do0;
    dbg_t          dbg0;

    sram_req_ctrl #(.AW(AW), .DW(DW), .INIT_EN(1'b1)) u_dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_byte(req_byte), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_a(sram_a), .sram_byte(sram_byte), .sram_di(sram_di),
        .sram_do(sram_do), .dbg(dbg)
    );

    sram_req_ctrl #(.AW(AW), .DW(DW), .INIT_EN(1'b0)) u_dut_noinit (
        .clk(clk), .rstn(rstn0),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_byte(req_byte0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .init_done(init_done0), .sram_cs(sram_cs0), .sram_we(sram_we0),
        .sram_a(sram_a0), .sram_byte(sram_byte0), .sram_di(sram_di0),
        .sram_do(sram_do0), .dbg(dbg0)
    );

    // Behavioural SRAM macro: registered read data, per-byte write enables.
    logic [DW-1:0] sram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = 32'hA5A5_0000 | DW'(i + 1);
        sram_do = '0;
        forever begin
            @(posedge clk);
            if (sram_cs) begin
                if (sram_we) begin
                    for (int b = 0; b < BW; b++)
                        if (sram_byte[b]) sram_mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
                end else begin
                    sram_do <= sram_mem[sram_a];
                end
            end
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            n_vec  = 0;
    int            n_fail = 0;
    int            cyc    = 0;
    logic          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Sample handshakes mid-low-phase, update model/scoreboard, advance one cycle.
    task automatic clk_step();
        #1;
        if (rsp_valid && rsp_ready) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL rsp_extra: observed response %h expected none", rsp_rdata);
            end
            if (exp_q.size() != 0) chk("rsp_data", rsp_rdata, exp_q.pop_front());
        end
        last_acc = req_valid && req_ready;
        if (last_acc) begin
            if (req_write) begin
                for (int b = 0; b < BW; b++)
                    if (req_byte[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
                exp_q.push_back(ref_mem[req_addr]);
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] be,
                        input logic [DW-1:0] d);
        int waited;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_byte = be; req_wdata = d;
        waited = 0;
        do begin
            clk_step();
            waited++;
        end while (!last_acc && waited < 50);
        n_vec++;
        assert (last_acc) else begin
            n_fail++;
            $error("FAIL send_accept: observed no acceptance expected acceptance within 50 cycles");
        end
    endtask

    task automatic drain(input string tag);
        req_valid = 1'b0;
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) clk_step();
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        #1;
        chk({tag, "_ctl"}, {req_ready, rsp_valid, init_done, sram_cs, sram_we}, 0);
        chk({tag, "_a_be"}, {sram_byte, sram_a}, 0);
        chk({tag, "_di"}, sram_di, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
        chk({tag, "_dbg"}, dbg, 0);
    endtask

    // Called at the negedge where rstn has just been released.
    task automatic check_init_seq(input string tag);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int k = 0; k <= DEPTH + 1; k++) begin
            #1;
            if (k == 0) begin
                chk({tag, "_rst_cs"}, sram_cs, 0);
            end else if (k <= DEPTH) begin
                chk({tag, "_fill"}, 32'({sram_cs, sram_we, sram_byte, sram_a}),
                    32'({1'b1, 1'b1, 4'hF, AW'(k - 1)}));
                chk({tag, "_fill_di"}, sram_di, 0);
            end
            if (k <= DEPTH) chk({tag, "_not_done"}, {init_done, req_ready}, 0);
            else begin
                chk({tag, "_done"}, init_done, 1);
                chk({tag, "_state"}, 32'(dbg.state), 32'(RUN));
            end
            if (k <= DEPTH) clk_step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, nxt, cyc0;
        rstn = 1'b1; rstn0 = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_byte = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = AW'(3); req_byte0 = '0;
        req_wdata0 = '0; rsp_ready0 = 1'b1; sram_do0 = '0;
        #2;
        rstn = 1'b0; rstn0 = 1'b0;
        repeat (3) @(negedge clk);

        chk_all_zero("reset");
        chk("reset_noinit", {req_ready0, init_done0, sram_cs0, rsp_valid0}, 0);

        rstn = 1'b1;
        check_init_seq("init1");

        // Every address reads back zero after the fill, one read per cycle.
        rsp_ready = 1'b1;
        cyc0 = cyc;
        for (int i = 0; i < DEPTH; i++) send(1'b0, AW'(i), '0, '0);
        chk("burst_cycles", cyc - cyc0, DEPTH);
        drain("zero_read");

        // Idle in RUN: nothing leaks onto the SRAM bus.
        req_valid = 1'b0; req_write = 1'b1; req_addr = AW'(9); req_byte = 4'hF;
        req_wdata = 32'h5555_AAAA;
        #1;
        chk("idle_bus", 32'({sram_cs, sram_we, sram_byte, sram_a}), 0);
        chk("idle_di", sram_di, 0);
        clk_step();

        // Write then immediate read of the same word; data two cycles after acceptance.
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(5); req_byte = 4'hF;
        req_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_pass", 32'({sram_cs, sram_we, sram_byte, sram_a}), 32'({2'b11, 4'hF, AW'(5)}));
        chk("wr_pass_di", sram_di, 32'hDEAD_BEEF);
        clk_step();
        chk("wr_accept", last_acc, 1);
        send(1'b0, AW'(5), '0, '0);
        req_valid = 1'b0;
        #1;
        chk("lat_n1_valid", rsp_valid, 0);
        clk_step();
        #1;
        chk("lat_n2_valid", rsp_valid, 1);
        chk("lat_n2_data", rsp_rdata, 32'hDEAD_BEEF);
        drain("raw");

        // Partial-byte write merges with the existing word.
        send(1'b1, AW'(2), 4'b1111, 32'h1122_3344);
        send(1'b1, AW'(2), 4'b0010, 32'h0000_AA00);
        send(1'b0, AW'(2), '0, '0);
        chk("be_expect", exp_q[exp_q.size() - 1], 32'h1122_AA44);
        drain("byte_en");

        // Back-pressure: only two reads fit while the consumer stalls.
        for (int i = 0; i < 4; i++) send(1'b1, AW'(i), 4'hF, 32'h0A0A_0000 + DW'(i * 32'h111));
        rsp_ready = 1'b0;
        acc = 0; nxt = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(nxt); req_byte = '0;
            clk_step();
            if (last_acc) begin acc++; nxt++; end
        end
        chk("bp_accepted", acc, 2);
        #1;
        chk("bp_ready_low", req_ready, 0);
        chk("bp_valid", rsp_valid, 1);
        chk("bp_head", rsp_rdata, exp_q[0]);
        clk_step();
        #1;
        chk("bp_head_held", rsp_rdata, exp_q[0]);
        chk("bp_still_full", dbg.fifo_full, 1);
        rsp_ready = 1'b1;
        cyc0 = cyc;
        for (int g = 0; g < 10 && nxt < 4; g++) begin
            req_addr = AW'(nxt);
            clk_step();
            if (last_acc) nxt++;
        end
        chk("bp_resume_cycles", cyc - cyc0, 2);
        drain("backpressure");

        // Reset from RUN, then reset again in the middle of the fill.
        rstn = 1'b0;
        chk_all_zero("run_reset");
        clk_step();
        rstn = 1'b1;
        repeat (8) clk_step();
        #1;
        chk("midinit_cnt", 32'({sram_cs, sram_a}), 32'({1'b1, AW'(7)}));
        rstn = 1'b0;
        chk_all_zero("midinit_reset");
        clk_step();
        chk_all_zero("midinit_hold");
        rstn = 1'b1;
        check_init_seq("init2");
        send(1'b0, AW'(5), '0, '0);
        drain("refill_read");

        // Without the fill the controller is ready one cycle after release.
        rstn0 = 1'b1;
        #1;
        chk("noinit_rst", {init_done0, req_ready0, sram_cs0}, 0);
        clk_step();
        #1;
        chk("noinit_done", {init_done0, req_ready0, sram_cs0, sram_we0}, 4'b1110);
        chk("noinit_addr", sram_a0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
